// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - shared memory port bundle between fetch, load/store and memory
//
// Signals
//   if_*  : fetch requester (req/addr in, gnt/rvalid/rdata out of the arbiter)
//   d_*   : load/store requester (req/we/addr/wdata in, gnt/rvalid/rdata out)
//   mem_* : memory side (en/we/addr/wdata out of the arbiter, rdata in)
// Modports
//   slave  : the arbiter
//   master : requesters plus memory model (testbench / surrounding core)
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single memory port arbiter between fetch and load/store
//
// Ports
//   clk     : main clock
//   reset_s : asynchronous active-low reset
//   halt    : core halted, blocks new grants and freezes the starvation counter
//   bus     : mem_port_arbiter_if.slave (fetch, data and memory signals)
//   busy    : a read is outstanding
// Parameters
//   READ_LAT   : cycles from grant to read data (1..4)
//   STARVE_MAX : refused fetch cycles before fetch beats data (1..15)
//   AW, DW     : address / data width
module mem_port_arbiter #(
    parameter int READ_LAT   = 1,
    parameter int STARVE_MAX = 4,
    parameter int AW         = 32,
    parameter int DW         = 32
) (
    input  logic                    clk,
    input  logic                    reset_s,
    input  logic                    halt,
    mem_port_arbiter_if.slave       bus,
    output logic                    busy
);

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_t;

    localparam logic       OWNER_IF   = 1'b0;
    localparam logic       OWNER_D    = 1'b1;
    localparam logic [2:0] LAT_LAST   = 3'(READ_LAT - 1);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t        state;
    logic [2:0]    lat_cnt;
    logic [3:0]    starve_cnt;
    logic          owner;
    logic [DW-1:0] if_rdata_q;
    logic [DW-1:0] d_rdata_q;

    logic resp_cycle;
    logic eligible;
    logic if_win;
    logic d_win;
    logic d_write;
    logic rd_grant;

    // The response cycle doubles as a grant slot so back-to-back reads
    // sustain one access per READ_LAT cycles.
    assign resp_cycle = (state == RD_WAIT) && (lat_cnt == LAT_LAST);

    // reset_s is folded in so the combinational grant path stays quiet while
    // reset is held, even with a requester active.
    assign eligible = reset_s && !halt && ((state == IDLE) || resp_cycle);

    assign if_win   = eligible && bus.if_req && (!bus.d_req || (starve_cnt == STARVE_LIM));
    assign d_win    = eligible && bus.d_req && !if_win;
    assign d_write  = d_win && bus.d_we;
    assign rd_grant = if_win || (d_win && !bus.d_we);

    assign bus.if_gnt    = if_win;
    assign bus.d_gnt     = d_win;
    assign bus.mem_en    = if_win || d_win;
    assign bus.mem_we    = d_write;
    assign bus.mem_addr  = if_win ? bus.if_addr : (d_win ? bus.d_addr : '0);
    assign bus.mem_wdata = d_write ? bus.d_wdata : '0;

    // Read data is steered straight from the memory in the response cycle;
    // outside it each requester sees the last word it received.
    assign bus.if_rvalid = resp_cycle && (owner == OWNER_IF);
    assign bus.d_rvalid  = resp_cycle && (owner == OWNER_D);
    assign bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : if_rdata_q;
    assign bus.d_rdata   = bus.d_rvalid  ? bus.mem_rdata : d_rdata_q;

    assign busy = (state == RD_WAIT);

    always_ff @(posedge clk or negedge reset_s) begin
        if (!reset_s) begin
            state      <= IDLE;
            lat_cnt    <= 3'd0;
            starve_cnt <= 4'd0;
            owner      <= OWNER_IF;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            // A write grant leaves the read sequencing alone: it falls through
            // to the response/count branches below.
            if (rd_grant) begin
                state   <= RD_WAIT;
                lat_cnt <= 3'd0;
                owner   <= if_win ? OWNER_IF : OWNER_D;
            end else if (resp_cycle) begin
                state   <= IDLE;
                lat_cnt <= 3'd0;
            end else if (state == RD_WAIT) begin
                lat_cnt <= lat_cnt + 3'd1;
            end

            if (bus.if_rvalid) begin
                if_rdata_q <= bus.mem_rdata;
            end
            if (bus.d_rvalid) begin
                d_rdata_q <= bus.mem_rdata;
            end

            if (!halt) begin
                if (bus.if_req && !if_win) begin
                    if (starve_cnt != STARVE_LIM) begin
                        starve_cnt <= starve_cnt + 4'd1;
                    end
                end else begin
                    starve_cnt <= 4'd0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic clk;
    logic reset_s;
    logic halt;
    logic busy_a;
    logic busy_b;

    int checks;
    int failures;

    mem_port_arbiter_if #(.AW(32), .DW(32)) bus_a ();
    mem_port_arbiter_if #(.AW(32), .DW(32)) bus_b ();

    mem_port_arbiter #(.READ_LAT(1), .STARVE_MAX(4), .AW(32), .DW(32)) dut_a (
        .clk     (clk),
        .reset_s (reset_s),
        .halt    (halt),
        .bus     (bus_a),
        .busy    (busy_a)
    );

    mem_port_arbiter #(.READ_LAT(3), .STARVE_MAX(4), .AW(32), .DW(32)) dut_b (
        .clk     (clk),
        .reset_s (reset_s),
        .halt    (halt),
        .bus     (bus_b),
        .busy    (busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge, checks 2 units later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle_a();
        bus_a.if_req = 1'b0; bus_a.if_addr = '0;
        bus_a.d_req = 1'b0; bus_a.d_we = 1'b0; bus_a.d_addr = '0; bus_a.d_wdata = '0;
        bus_a.mem_rdata = '0;
    endtask

    task automatic idle_b();
        bus_b.if_req = 1'b0; bus_b.if_addr = '0;
        bus_b.d_req = 1'b0; bus_b.d_we = 1'b0; bus_b.d_addr = '0; bus_b.d_wdata = '0;
        bus_b.mem_rdata = '0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset_s  = 1'b0;
        halt     = 1'b0;
        idle_a();
        idle_b();

        // ---------------- reset held with a fetch request ----------------
        repeat (2) @(posedge clk);
        #1;
        bus_a.if_req = 1'b1; bus_a.if_addr = 32'h10;
        settle();
        check("rst_if_gnt",   64'(bus_a.if_gnt),    64'd0);
        check("rst_mem_en",   64'(bus_a.mem_en),    64'd0);
        check("rst_mem_addr", 64'(bus_a.mem_addr),  64'd0);
        check("rst_if_rv",    64'(bus_a.if_rvalid), 64'd0);
        check("rst_if_rdata", 64'(bus_a.if_rdata),  64'd0);
        check("rst_busy",     64'(busy_a),          64'd0);

        next_cycle();
        reset_s = 1'b1;
        settle();
        check("rel_if_gnt",   64'(bus_a.if_gnt),   64'd1);
        check("rel_mem_en",   64'(bus_a.mem_en),   64'd1);
        check("rel_mem_addr", 64'(bus_a.mem_addr), 64'h10);
        check("rel_mem_we",   64'(bus_a.mem_we),   64'd0);

        next_cycle();
        bus_a.if_req = 1'b0;
        bus_a.mem_rdata = 32'hE3A00001;
        settle();
        check("rel_if_rv",    64'(bus_a.if_rvalid), 64'd1);
        check("rel_if_rdata", 64'(bus_a.if_rdata),  64'hE3A00001);
        check("rel_busy",     64'(busy_a),          64'd1);
        check("rel_d_rv",     64'(bus_a.d_rvalid),  64'd0);

        next_cycle();
        bus_a.mem_rdata = 32'h0;
        settle();
        check("rel_if_rv_off",  64'(bus_a.if_rvalid), 64'd0);
        check("rel_rdata_hold", 64'(bus_a.if_rdata),  64'hE3A00001);
        check("rel_busy_off",   64'(busy_a),          64'd0);

        // ---------------- priority: data beats fetch ----------------
        next_cycle();
        bus_a.if_req = 1'b1; bus_a.if_addr = 32'h20;
        bus_a.d_req = 1'b1; bus_a.d_we = 1'b0; bus_a.d_addr = 32'h100;
        settle();
        check("pri_d_gnt",    64'(bus_a.d_gnt),    64'd1);
        check("pri_if_gnt",   64'(bus_a.if_gnt),   64'd0);
        check("pri_mem_addr", 64'(bus_a.mem_addr), 64'h100);

        next_cycle();
        bus_a.d_req = 1'b0;
        bus_a.mem_rdata = 32'h55AA;
        settle();
        check("pri_d_rv",      64'(bus_a.d_rvalid),  64'd1);
        check("pri_d_rdata",   64'(bus_a.d_rdata),   64'h55AA);
        check("pri_if_gnt2",   64'(bus_a.if_gnt),    64'd1);
        check("pri_mem_addr2", 64'(bus_a.mem_addr),  64'h20);
        check("pri_if_rv0",    64'(bus_a.if_rvalid), 64'd0);

        next_cycle();
        bus_a.if_req = 1'b0;
        bus_a.mem_rdata = 32'h1234;
        settle();
        check("pri_if_rv",    64'(bus_a.if_rvalid), 64'd1);
        check("pri_if_rdata", 64'(bus_a.if_rdata),  64'h1234);
        check("pri_d_hold",   64'(bus_a.d_rdata),   64'h55AA);

        // ---------------- starvation bound ----------------
        next_cycle();
        idle_a();
        settle();
        for (int k = 1; k <= 5; k++) begin
            next_cycle();
            bus_a.if_req = 1'b1; bus_a.if_addr = 32'h24;
            bus_a.d_req = 1'b1; bus_a.d_we = 1'b0; bus_a.d_addr = 32'h104;
            settle();
            check($sformatf("stv_if_gnt%0d", k), 64'(bus_a.if_gnt), 64'(k == 5));
            check($sformatf("stv_d_gnt%0d", k),  64'(bus_a.d_gnt),  64'(k != 5));
        end
        next_cycle();
        idle_a();
        bus_a.mem_rdata = 32'h7777;
        settle();
        check("stv_if_rv",    64'(bus_a.if_rvalid), 64'd1);
        check("stv_if_rdata", 64'(bus_a.if_rdata),  64'h7777);

        // ---------------- data write ----------------
        next_cycle();
        bus_a.mem_rdata = 32'h0;
        bus_a.if_req = 1'b1; bus_a.if_addr = 32'h30;
        bus_a.d_req = 1'b1; bus_a.d_we = 1'b1; bus_a.d_addr = 32'h40; bus_a.d_wdata = 32'hDEADBEEF;
        settle();
        check("wr_d_gnt",     64'(bus_a.d_gnt),     64'd1);
        check("wr_mem_en",    64'(bus_a.mem_en),    64'd1);
        check("wr_mem_we",    64'(bus_a.mem_we),    64'd1);
        check("wr_mem_addr",  64'(bus_a.mem_addr),  64'h40);
        check("wr_mem_wdata", 64'(bus_a.mem_wdata), 64'hDEADBEEF);

        next_cycle();
        bus_a.d_req = 1'b0; bus_a.d_we = 1'b0; bus_a.d_wdata = '0;
        settle();
        check("wr_d_rv",       64'(bus_a.d_rvalid),  64'd0);
        check("wr_busy",       64'(busy_a),          64'd0);
        check("wr_if_gnt",     64'(bus_a.if_gnt),    64'd1);
        check("wr_mem_we2",    64'(bus_a.mem_we),    64'd0);
        check("wr_mem_wdata2", 64'(bus_a.mem_wdata), 64'd0);

        next_cycle();
        bus_a.if_req = 1'b0;
        settle();
        check("wr_if_rv", 64'(bus_a.if_rvalid), 64'd1);

        // ---------------- halt ----------------
        next_cycle();
        idle_a();
        settle();
        next_cycle();
        bus_a.if_req = 1'b1; bus_a.if_addr = 32'h60;
        bus_a.d_req = 1'b1; bus_a.d_we = 1'b0; bus_a.d_addr = 32'h160;
        settle();
        check("hlt_d_gnt0", 64'(bus_a.d_gnt), 64'd1);
        for (int k = 1; k <= 3; k++) begin
            next_cycle();
            halt = 1'b1;
            settle();
            check($sformatf("hlt_if_gnt%0d", k), 64'(bus_a.if_gnt), 64'd0);
            check($sformatf("hlt_d_gnt%0d", k),  64'(bus_a.d_gnt),  64'd0);
            check($sformatf("hlt_d_rv%0d", k),   64'(bus_a.d_rvalid), 64'(k == 1));
        end
        // starve_cnt was 1 entering halt; three more refusals lift it to 4.
        for (int k = 4; k <= 7; k++) begin
            next_cycle();
            halt = 1'b0;
            settle();
            check($sformatf("hlt_if_gnt%0d", k), 64'(bus_a.if_gnt), 64'(k == 7));
            check($sformatf("hlt_d_gnt%0d", k),  64'(bus_a.d_gnt),  64'(k != 7));
        end
        next_cycle();
        idle_a();
        settle();
        check("hlt_if_rv_end", 64'(bus_a.if_rvalid), 64'd1);

        // ---------------- READ_LAT=3 streaming fetch ----------------
        for (int k = 0; k <= 13; k++) begin
            next_cycle();
            bus_b.if_req = (k <= 9);
            bus_b.if_addr = 32'h1000 + 32'(k);
            bus_b.mem_rdata = 32'hA0000000 + 32'(k);
            settle();
            check($sformatf("lat_gnt%0d", k),  64'(bus_b.if_gnt),    64'((k <= 9) && (k % 3 == 0)));
            check($sformatf("lat_rv%0d", k),   64'(bus_b.if_rvalid), 64'((k > 0) && (k % 3 == 0) && (k <= 12)));
            check($sformatf("lat_busy%0d", k), 64'(busy_b),          64'((k > 0) && (k <= 12)));
            if (k == 6) begin
                check("lat_rdata6", 64'(bus_b.if_rdata), 64'hA0000006);
            end
        end

        // ---------------- reset during an outstanding read ----------------
        next_cycle();
        idle_b();
        bus_b.d_req = 1'b1; bus_b.d_addr = 32'h200;
        settle();
        check("mrst_d_gnt", 64'(bus_b.d_gnt), 64'd1);

        next_cycle();
        bus_b.d_req = 1'b0;
        reset_s = 1'b0;
        settle();
        check("mrst_busy", 64'(busy_b),         64'd0);
        check("mrst_d_rv", 64'(bus_b.d_rvalid), 64'd0);

        next_cycle();
        bus_b.if_req = 1'b1; bus_b.if_addr = 32'h300;
        settle();
        check("mrst_if_gnt_hold", 64'(bus_b.if_gnt), 64'd0);

        next_cycle();
        reset_s = 1'b1;
        settle();
        check("mrst_if_gnt",   64'(bus_b.if_gnt),   64'd1);
        check("mrst_d_gnt2",   64'(bus_b.d_gnt),    64'd0);
        check("mrst_mem_addr", 64'(bus_b.mem_addr), 64'h300);

        for (int k = 1; k <= 3; k++) begin
            next_cycle();
            bus_b.if_req = 1'b0;
            settle();
            check($sformatf("mrst_d_rv%0d", k),  64'(bus_b.d_rvalid),  64'd0);
            check($sformatf("mrst_if_rv%0d", k), 64'(bus_b.if_rvalid), 64'(k == 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single instruction/data memory port between the fetch stage and the load/store path of decode.
- Grants one access at a time and sequences the fixed read latency of the memory.
- Returns read data to the correct requester with a one-cycle valid strobe.
- Gates new grants while the core is halted. Sits between IF/ID and the memory model and replaces direct IF/ID drive of the memory enable, address and read/write strobes.

Parameters:
- READ_LAT, 1: cycles from grant to valid memory read data (legal 1..4).
- STARVE_MAX, 4: consecutive cycles fetch may be refused before it wins over data (legal 1..15).
- AW, 32: address width.
- DW, 32: data width.

Ports:
- clk  in  1  main clock
- reset_s  in  1  asynchronous, active-low reset
- halt  in  1  core halted; no new grants
- if_req  in  1  fetch request
- if_addr  in  AW  fetch address
- if_gnt  out  1  fetch granted this cycle
- if_rvalid  out  1  fetch data valid
- if_rdata  out  DW  fetched instruction
- d_req  in  1  data request
- d_we  in  1  1 = write, 0 = read
- d_addr  in  AW  data address
- d_wdata  in  DW  write data
- d_gnt  out  1  data granted this cycle
- d_rvalid  out  1  load data valid
- d_rdata  out  DW  load data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write strobe
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data
- busy  out  1  read outstanding

Behaviour:
- Reset (reset_s=0, async): all outputs 0, state IDLE, lat_cnt=0, starve_cnt=0, owner=IF. Any outstanding read is discarded and produces no rvalid.
- States:
  - IDLE: no read outstanding.
  - RD_WAIT: read outstanding; lat_cnt counts up to READ_LAT.
- Grant eligibility in cycle C: halt=0, and either state==IDLE or (state==RD_WAIT and lat_cnt==READ_LAT-1, i.e. the response cycle).
- Responses and new grants overlap: back-to-back reads reach one read per READ_LAT cycles.
- Arbitration when both request:
  - d_req wins, unless starve_cnt==STARVE_MAX, in which case if_req wins.
  - A single requester always wins.
- starve_cnt:
  - +1 (saturating at STARVE_MAX) in every cycle with if_req=1 and if_gnt=0.
  - Cleared on if_gnt or when if_req=0.
- Grant cycle is combinational in the same cycle:
  - gnt=1, mem_en=1, mem_addr = winner address.
  - For data writes: mem_we=1 and mem_wdata=d_wdata; for all other accesses mem_we=0 and mem_wdata=0.
  - With no grant: mem_en=0, mem_we=0, mem_addr=0.
- Data write: completes in the grant cycle. No rvalid is issued and the state is unchanged (remains IDLE, or stays in the current RD_WAIT response cycle).
- Read grant: owner is latched, lat_cnt=0, next state RD_WAIT.
- Read response:
  - In cycle G+READ_LAT, owner's rvalid=1 for exactly one cycle and owner's rdata=mem_rdata.
  - The non-owner rdata holds its last value.
  - Next state is IDLE, unless a new read is granted in the same cycle (then RD_WAIT, lat_cnt=0).
- busy=1 while in RD_WAIT.
- Requester rules:
  - req, addr, we and wdata are held stable until gnt.
  - Dropping req before gnt withdraws the request without side effects.
  - The same requester may re-request in its own rvalid cycle.
- halt:
  - Blocks new grants and freezes starve_cnt.
  - An outstanding read still completes and delivers rvalid.
  - Requests resume arbitration the first cycle after halt=0.
- At most one read is outstanding; rvalid never asserts on both requesters in the same cycle.

Test Plan:
- Reset: hold reset_s=0 with if_req=1 -> all outputs 0. Release -> if_gnt in the first cycle; with READ_LAT=1, if_rvalid the next cycle with if_rdata=mem_rdata (0xE3A00001).
- Priority: if_req and d_req (read, addr 0x100) both high from IDLE -> d_gnt first, mem_addr=0x100. if_gnt in d_rvalid's cycle. With STARVE_MAX=4 and d_req held continuously, if_gnt occurs no later than the 5th contention grant slot.
- Write: d_req=1, d_we=1, addr 0x40, wdata 0xDEADBEEF -> mem_en=1, mem_we=1, mem_wdata=0xDEADBEEF in the same cycle. d_rvalid stays 0; a fetch is granted the next cycle.
- Latency: READ_LAT=3, continuous if_req -> grants every 3 cycles; each if_rvalid lands 3 cycles after its grant, coinciding with the next grant; busy stays 1.
- Halt: assert halt one cycle after a read grant -> that read's rvalid still appears. No further gnt while halt=1; starve_cnt is unchanged across the halt.
- Reset mid-read: drop reset_s during RD_WAIT -> no rvalid afterwards, busy=0, and the first post-reset grant goes to the sole requester.
